// File: rtl/iir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iir_pkg
// Description : Shared definitions for the IIR filter stream sink: default
//               sample width, statistics counter width and a saturating
//               increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package iir_pkg;

  // Default sample width, matching the filter data path
  localparam int DW_DEFAULT = 8;

  // Width of the accepted/dropped statistics counters
  localparam int CNT_W = 16;

  // Increment that sticks at the all-ones value instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] i_val);
    return (&i_val) ? i_val : i_val + CNT_W'(1);
  endfunction

endpackage : iir_pkg
`default_nettype wire

// File: rtl/sink_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : sink_fifo_mem
// Description : DEPTH x DW storage array for the stream sink FIFO. One
//               synchronous write port, one registered read port. The array
//               itself is not reset; only the read data register is.
// Ports       : i_clk   - clock
//               i_rst   - async active-high reset (read register only)
//               i_clr   - synchronous clear of the read register
//               i_we    - write enable
//               i_waddr - write address
//               i_wdata - write data
//               i_re    - read enable
//               i_raddr - read address
//               o_rdata - registered read data, holds when i_re is low
// Revision    : 1.0 - initial release
// ============================================================================
module sink_fifo_mem
  import iir_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // The read samples the array before this edge's write lands, so a read
  // and write to the same slot (full FIFO, pop + push) returns the old entry.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (i_clr) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule : sink_fifo_mem
`default_nettype wire

// File: rtl/iir_stream_sink.sv
`default_nettype none
// ============================================================================
// Module      : iir_stream_sink
// Description : Capture sink for the IIR filter output stream. Buffers every
//               valid sample in a FIFO, drains it through a request/valid
//               read port, counts accepted and dropped samples and raises
//               DONE after N_SAMPLES arrivals.
// Ports       : CLK, RST (async, active-high), CLR (sync clear)
//               VIN/DIN       - input stream from filter VOUT/DOUT
//               RD_REQ        - pop request
//               DOUT/VOUT     - registered popped sample and valid pulse
//               FULL/EMPTY/LEVEL - occupancy
//               OVF, RX_CNT, DROP_CNT, DONE - statistics
// Revision    : 1.0 - initial release
// ============================================================================
module iir_stream_sink
  import iir_pkg::*;
#(
  parameter int DW        = DW_DEFAULT,
  parameter int DEPTH     = 16,
  parameter int N_SAMPLES = 0,
  localparam int AW       = $clog2(DEPTH),
  localparam int LW       = AW + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             VIN,
  input  logic [DW-1:0]    DIN,
  input  logic             RD_REQ,
  output logic [DW-1:0]    DOUT,
  output logic             VOUT,
  output logic             FULL,
  output logic             EMPTY,
  output logic [LW-1:0]    LEVEL,
  output logic             OVF,
  output logic [CNT_W-1:0] RX_CNT,
  output logic [CNT_W-1:0] DROP_CNT,
  output logic             DONE
);

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_full;
  logic             r_empty;
  logic             r_vout;
  logic             r_ovf;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [CNT_W-1:0] r_drop_cnt;
  logic [31:0]      r_arr_cnt;
  logic             r_done;

  logic             w_pop;
  logic             w_wr;
  logic             w_drop;
  logic [LW-1:0]    w_level_nxt;
  logic [31:0]      w_arr_nxt;
  logic             w_done_hit;

  // A pop on a full FIFO frees the slot that the same-cycle write takes
  assign w_pop  = RD_REQ & ~r_empty;
  assign w_wr   = VIN & (~r_full | w_pop);
  assign w_drop = VIN & r_full & ~w_pop;

  always_comb begin
    w_level_nxt = r_level;
    if (w_wr && !w_pop) begin
      w_level_nxt = r_level + LW'(1);
    end else if (!w_wr && w_pop) begin
      w_level_nxt = r_level - LW'(1);
    end
  end

  // Arrival counter saturates so DONE can never re-trigger by wrapping
  assign w_arr_nxt  = (&r_arr_cnt) ? r_arr_cnt : r_arr_cnt + 32'd1;
  assign w_done_hit = (N_SAMPLES != 0) && VIN && (w_arr_nxt == 32'(N_SAMPLES));

  sink_fifo_mem #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_mem (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_clr   (CLR),
    .i_we    (w_wr & ~CLR),
    .i_waddr (r_wr_ptr),
    .i_wdata (DIN),
    .i_re    (w_pop & ~CLR),
    .i_raddr (r_rd_ptr),
    .o_rdata (DOUT)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_vout     <= 1'b0;
      r_ovf      <= 1'b0;
      r_rx_cnt   <= '0;
      r_drop_cnt <= '0;
      r_arr_cnt  <= '0;
      r_done     <= 1'b0;
    end else if (CLR) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_vout     <= 1'b0;
      r_ovf      <= 1'b0;
      r_rx_cnt   <= '0;
      r_drop_cnt <= '0;
      r_arr_cnt  <= '0;
      r_done     <= 1'b0;
    end else begin
      r_vout  <= w_pop;
      r_level <= w_level_nxt;
      // Flags come from the occupancy counter; equal pointers are ambiguous
      r_full  <= (w_level_nxt == LW'(DEPTH));
      r_empty <= (w_level_nxt == '0);
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        r_rx_cnt <= sat_inc(r_rx_cnt);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_drop) begin
        r_ovf      <= 1'b1;
        r_drop_cnt <= sat_inc(r_drop_cnt);
      end
      if (VIN) begin
        r_arr_cnt <= w_arr_nxt;
      end
      if (w_done_hit) begin
        r_done <= 1'b1;
      end
    end
  end

  assign VOUT     = r_vout;
  assign FULL     = r_full;
  assign EMPTY    = r_empty;
  assign LEVEL    = r_level;
  assign OVF      = r_ovf;
  assign RX_CNT   = r_rx_cnt;
  assign DROP_CNT = r_drop_cnt;
  assign DONE     = r_done;

endmodule : iir_stream_sink
`default_nettype wire

// File: tb/tb_iir_stream_sink.sv
`default_nettype none
// ============================================================================
// Module      : tb_iir_stream_sink
// Description : Self-checking bench for iir_stream_sink. A queue-based model
//               predicts every output after each clock edge; directed
//               sequences add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iir_stream_sink;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int NS    = 10;

  logic          CLK, RST, CLR, VIN, RD_REQ;
  logic [DW-1:0] DIN;
  logic [DW-1:0] DOUT;
  logic          VOUT, FULL, EMPTY, OVF, DONE;
  logic [4:0]    LEVEL;
  logic [15:0]   RX_CNT, DROP_CNT;

  iir_stream_sink #(.DW(DW), .DEPTH(DEPTH), .N_SAMPLES(NS)) dut (
    .CLK(CLK), .RST(RST), .CLR(CLR), .VIN(VIN), .DIN(DIN), .RD_REQ(RD_REQ),
    .DOUT(DOUT), .VOUT(VOUT), .FULL(FULL), .EMPTY(EMPTY), .LEVEL(LEVEL),
    .OVF(OVF), .RX_CNT(RX_CNT), .DROP_CNT(DROP_CNT), .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [7:0] m_q[$];
  logic [7:0] m_dout;
  logic       m_vout, m_ovf, m_done;
  int         m_rx, m_drop, m_arr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_dout = '0; m_vout = 1'b0; m_ovf = 1'b0; m_done = 1'b0;
    m_rx = 0; m_drop = 0; m_arr = 0;
  endtask

  // Applies the sink's rules to the inputs seen at one clock edge
  task automatic model_edge();
    bit pop, full;
    if (CLR) begin
      model_reset();
      return;
    end
    full = (m_q.size() == DEPTH);
    pop  = RD_REQ && (m_q.size() > 0);
    m_vout = pop;
    if (pop) m_dout = m_q.pop_front();
    if (VIN) begin
      if (!full || pop) begin
        m_q.push_back(DIN);
        if (m_rx < 65535) m_rx++;
      end else begin
        m_ovf = 1'b1;
        if (m_drop < 65535) m_drop++;
      end
      m_arr++;
      if (m_arr == NS) m_done = 1'b1;
    end
  endtask

  task automatic compare_all();
    chk("dout",  32'(DOUT),     32'(m_dout));
    chk("vout",  32'(VOUT),     32'(m_vout));
    chk("full",  32'(FULL),     32'(m_q.size() == DEPTH));
    chk("empty", 32'(EMPTY),    32'(m_q.size() == 0));
    chk("level", 32'(LEVEL),    32'(m_q.size()));
    chk("ovf",   32'(OVF),      32'(m_ovf));
    chk("rx",    32'(RX_CNT),   32'(m_rx));
    chk("drop",  32'(DROP_CNT), 32'(m_drop));
    chk("done",  32'(DONE),     32'(m_done));
  endtask

  // Drive one cycle of inputs, clock it, update model, compare 1 unit later
  task automatic step(input bit vin, input logic [7:0] din, input bit rd, input bit clr);
    VIN = vin; DIN = din; RD_REQ = rd; CLR = clr;
    @(posedge CLK);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dout"},  32'(DOUT), 0);
    chk({tag, "_vout"},  32'(VOUT), 0);
    chk({tag, "_full"},  32'(FULL), 0);
    chk({tag, "_empty"}, 32'(EMPTY), 1);
    chk({tag, "_level"}, 32'(LEVEL), 0);
    chk({tag, "_ovf"},   32'(OVF), 0);
    chk({tag, "_rx"},    32'(RX_CNT), 0);
    chk({tag, "_drop"},  32'(DROP_CNT), 0);
    chk({tag, "_done"},  32'(DONE), 0);
  endtask

  initial begin
    RST = 1'b1; CLR = 1'b0; VIN = 1'b0; RD_REQ = 1'b0; DIN = '0;
    model_reset();
    #1;
    chk_reset_vals("por");
    #12 RST = 1'b0;

    // Five writes then five pops, in order
    for (int i = 1; i <= 5; i++) step(1, 8'(i), 0, 0);
    chk("t1_level", 32'(LEVEL), 5);
    for (int i = 1; i <= 5; i++) begin
      step(0, 8'h00, 1, 0);
      chk("t1_pop_dout", 32'(DOUT), 32'(i));
      chk("t1_pop_vout", 32'(VOUT), 1);
    end
    chk("t1_empty", 32'(EMPTY), 1);
    chk("t1_rx", 32'(RX_CNT), 5);
    chk("t1_ovf", 32'(OVF), 0);

    // Overflow: 16 fills then 3 drops, contents untouched
    step(0, 8'h00, 0, 1);
    for (int i = 0; i < 16; i++) step(1, 8'(8'h10 + i), 0, 0);
    for (int i = 0; i < 3; i++) step(1, 8'(8'hA0 + i), 0, 0);
    chk("t2_full", 32'(FULL), 1);
    chk("t2_ovf", 32'(OVF), 1);
    chk("t2_drop", 32'(DROP_CNT), 3);
    chk("t2_rx", 32'(RX_CNT), 16);
    for (int i = 0; i < 16; i++) begin
      step(0, 8'h00, 1, 0);
      chk("t2_pop_dout", 32'(DOUT), 32'(8'h10 + i));
    end
    chk("t2_empty", 32'(EMPTY), 1);

    // Sustained write+pop at full occupancy
    step(0, 8'h00, 0, 1);
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
    for (int i = 0; i < 40; i++) begin
      step(1, 8'($urandom_range(0, 255)), 1, 0);
      chk("t3_level", 32'(LEVEL), 16);
    end
    chk("t3_drop", 32'(DROP_CNT), 0);
    chk("t3_first_out", 32'(m_q.size()), 16);

    // DONE after the 10th arrival, sticky afterwards
    step(0, 8'h00, 0, 1);
    for (int i = 0; i < 12; i++) begin
      step(1, 8'(8'h40 + i), 0, 0);
      chk("t4_done", 32'(DONE), 32'(i >= 9));
    end

    // Read while empty, then CLR together with VIN
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 1, 0);
    chk("t5_vout_empty", 32'(VOUT), 0);
    step(1, 8'h77, 0, 1);
    chk("t5_clr_rx", 32'(RX_CNT), 0);
    chk("t5_clr_empty", 32'(EMPTY), 1);

    // Async reset mid-burst, held across one edge, released off-edge
    for (int i = 0; i < 8; i++) step(1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 0);
    #2 RST = 1'b1;
    #1;
    chk_reset_vals("arst");
    model_reset();
    #10;
    chk_reset_vals("arst_hold");
    #2 RST = 1'b0;
    step(1, 8'hC3, 0, 0);
    step(0, 8'h00, 1, 0);
    chk("t6_resume_dout", 32'(DOUT), 32'h00C3);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 99) == 0));
    end
    for (int i = 0; i < 20; i++) step(0, 8'h00, 1, 0);
    chk("final_empty", 32'(EMPTY), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_iir_stream_sink
`default_nettype wire
